// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scanner: digit count and active-low
// segment patterns, bit order {g,f,e,d,c,b,a}.
package sevseg_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble-to-segment decoder; non-BCD nibbles 10-15 show a dash.
module bcd_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with registered an/seg outputs.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_seg_scan
  import sevseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic          blank;
  logic          wrap;

  bcd_to_seg u_dec (
    .nibble_i (nibble),
    .seg_o    (pattern)
  );

`ifdef SEVSEG_LZ_BLANK_EN
  // lead_zero[k]: digit k and every digit above it are zero.
  logic [3:0] lead_zero;
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] & (disp_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] & (disp_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    blank        = lead_zero[idx_q];
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are built from the current index/display, so a load or advance
  // shows up on the very next edge with no intermediate mixed state.
  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    disp_d = bcd_valid ? bcd : disp_q;
    nibble = disp_q[{idx_q, 2'b00} +: 4];
    an_d   = ~(4'b0001 << idx_q);
    seg_d  = blank ? SEG_BLANK : pattern;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      disp_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (REFRESH_DIV=4), with a cycle-level model
// derived from elapsed-edge arithmetic; honours SEVSEG_LZ_BLANK_EN if defined.
module tb_seven_seg_scan;
  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scan #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEVSEG_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
  localparam bit LZ_ON = 1'b1;
`else
  localparam logic [6:0] LZ = 7'b1000000;
  localparam bit LZ_ON = 1'b0;
`endif

  logic [6:0] pat_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  logic [3:0] an_tab [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what digit d of value v must look like on the display.
  function automatic logic [6:0] model_seg(input logic [15:0] v, input int d);
    logic [15:0] upper;
    logic [3:0]  n;
    upper = v >> (4 * d);
    n     = upper[3:0];
    if (LZ_ON && d > 0 && upper == 16'h0000) return 7'b1111111;
    if (n > 4'd9) return 7'b0111111;
    return pat_tab[n];
  endfunction

  // Model state: edges since reset and the last value loaded.
  bit          m_on = 1'b0;
  int          m_edges;
  logic [15:0] m_disp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;

  always @(posedge clk) begin
    int dig;
    if (rst) begin
      m_on    = 1'b1;
      m_edges = 0;
      m_disp  = 16'h0000;
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
    end else if (m_on) begin
      dig     = (m_edges / DIV) % 4;
      exp_an  = an_tab[dig];
      exp_seg = model_seg(m_disp, dig);
      m_edges = m_edges + 1;
      if (bcd_valid) m_disp = bcd;
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (m_on) begin
      chk("model_an", {4'b0, an}, {4'b0, exp_an});
      chk("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      chk("model_dp", {7'b0, dp}, 8'h01);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Load v, then walk one full 16-edge scan. Entry point must be scan-aligned.
  task automatic scan(input logic [15:0] v, input logic [6:0] sf,
                      input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] st [0:3];
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    bcd = v;
    bcd_valid = 1'b1;
    cyc();
    bcd_valid = 1'b0;
    chk("scan_first_an", {4'b0, an}, 8'b0000_1110);
    chk("scan_first_seg", {1'b0, seg}, {1'b0, sf});
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("scan_an", {4'b0, an}, {4'b0, an_tab[i / 4]});
      chk("scan_seg", {1'b0, seg}, {1'b0, st[i / 4]});
    end
  endtask

  initial begin
    rst = 1'b1;
    bcd = 16'h0000;
    bcd_valid = 1'b0;
    cyc();
    cyc();
    chk("reset_an", {4'b0, an}, 8'b0000_1111);
    chk("reset_seg", {1'b0, seg}, 8'b0111_1111);
    chk("reset_dp", {7'b0, dp}, 8'h01);

    rst = 1'b0;
    scan(16'h1234, 7'b1000000, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    scan(16'h0007, 7'b0011001, 7'b1111000, LZ, LZ, LZ);
    scan(16'h00A5, 7'b1111000, 7'b0010010, 7'b0111111, LZ, LZ);

    // load on the counter-wrap edge
    cyc(); cyc(); cyc();
    bcd = 16'h5555;
    bcd_valid = 1'b1;
    cyc();
    bcd_valid = 1'b0;
    chk("wrap_load_an_before", {4'b0, an}, 8'b0000_1110);
    cyc();
    chk("wrap_load_an", {4'b0, an}, 8'b0000_1101);
    chk("wrap_load_seg", {1'b0, seg}, 8'b0001_0010);
    for (int i = 0; i < 11; i++) cyc();

    // reset mid-scan together with a load
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    bcd = 16'h9999;
    bcd_valid = 1'b1;
    cyc();
    chk("midrst_an", {4'b0, an}, 8'b0000_1111);
    chk("midrst_seg", {1'b0, seg}, 8'b0111_1111);
    rst = 1'b0;
    bcd_valid = 1'b0;
    cyc();
    chk("midrst_release_an", {4'b0, an}, 8'b0000_1110);
    chk("midrst_release_seg", {1'b0, seg}, 8'b0100_0000);
    for (int i = 0; i < 4; i++) cyc();
    chk("midrst_digit1_an", {4'b0, an}, 8'b0000_1101);
    chk("midrst_digit1_seg", {1'b0, seg}, {1'b0, LZ});
    for (int i = 0; i < 20; i++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles each digit stays lit (>=2).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bcd  input  16  four BCD digits: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-005 SHALL have port bcd_valid  input  1  load strobe; bcd is captured on any rising edge where it is high.
REQ-006 SHALL have port an  output  4  digit enables, active-low, an[0] = ones digit.
REQ-007 SHALL have port seg  output  7  segments active-low, seg[0]=a through seg[6]=g.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, always driven 1 (off) outside reset too.

Function
REQ-009 SHALL hold a 16-bit display register, loaded from bcd on a clock edge with bcd_valid=1, otherwise unchanged.
REQ-010 SHALL run a refresh counter 0..REFRESH_DIV-1, wrapping to 0, free-running and never cleared by bcd_valid.
REQ-011 SHALL advance a 2-bit digit index 0->1->2->3->0 on the edge where the counter wraps.
REQ-012 SHALL register an and seg: outputs reflect the index and display register one cycle after they change.
REQ-013 SHALL drive exactly one an bit low at a time outside reset: an = ~(4'b0001 << index).
REQ-014 SHALL decode digit values 0-9 to standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-015 SHALL decode nibble values 10-15 as a dash, seg = 7'b0111111.
REQ-016 SHALL make a newly loaded value visible on each digit at that digit's next registered output update, with no glitch on the others.
REQ-017 SHALL, on a load coinciding with an index advance, display the new value on the newly selected digit.

Reset
REQ-018 SHALL, with rst=1 at a clock edge, clear counter, index and display register to 0 and set an=4'b1111, seg=7'b1111111, dp=1.
REQ-019 SHALL give rst priority over bcd_valid on the same edge.
REQ-020 SHALL, on the first edge after rst deasserts, drive an=4'b1110 with seg showing digit 0 of the display register.
REQ-021 SHALL, on reset mid-scan, abandon the current digit and restart at index 0 with counter 0.

Configuration
REQ-022 SHALL use macro SEVSEG_LZ_BLANK_EN for leading-zero blanking.
REQ-023 SHALL, with SEVSEG_LZ_BLANK_EN defined, drive seg=7'b1111111 for digit k (k=3,2,1) when digit k and all higher digits equal 0; digit 0 never blanked; an scanning unchanged.
REQ-024 SHALL, without SEVSEG_LZ_BLANK_EN, display all four digits including leading zeros.
REQ-025 SHALL treat a nonzero nibble 10-15 as non-zero for blanking.

Structure
REQ-026 SHALL place in package sevseg_pkg: digit count (4), SEG_BLANK, SEG_DASH, and the ten digit pattern constants.
REQ-027 SHALL instantiate one combinational sub-module bcd_to_seg (4-bit nibble in, 7-bit active-low pattern out).
REQ-028 SHALL size the refresh counter as $clog2(REFRESH_DIV) bits.

Verification (REFRESH_DIV=4)
REQ-029 SHALL cover: rst 2 cycles -> an=1111, seg=1111111, dp=1; first edge after release -> an=1110, seg=1000000.
REQ-030 SHALL cover: load 16'h1234, run 16 cycles -> an sequence 1110,1101,1011,0111, each held 4 cycles, seg = 4,3,2,1 patterns respectively.
REQ-031 SHALL cover: load 16'h0007 with macro -> digits 3..1 seg=1111111, digit 0 seg=1111000; without macro -> digits 3..1 seg=1000000.
REQ-032 SHALL cover: load 16'h00A5 -> digit 1 seg=0111111 (dash), digit 0 shows 5; with macro digits 3,2 blank.
REQ-033 SHALL cover: rst and bcd_valid (16'h9999) together mid-scan -> display register 0, next edge an=1110, seg=1000000.
REQ-034 SHALL cover: bcd_valid (16'h5555) on the counter-wrap edge -> newly selected digit shows 5 on the following edge.
